// File: rtl/switch_rr_scheduler.sv
// Round-robin scheduler moving head words of three input RAMs to three output RAMs.
// Define SCHED_STATS_EN to add the drop_cnt / conflict_cnt statistics ports.
module switch_rr_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] in_wr_add1,
    input  logic [ADDR_W-1:0] in_wr_add2,
    input  logic [ADDR_W-1:0] in_wr_add3,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [ADDR_W-1:0] in_rd_add1,
    output logic [ADDR_W-1:0] in_rd_add2,
    output logic [ADDR_W-1:0] in_rd_add3,
    output logic              in_rden1,
    output logic              in_rden2,
    output logic              in_rden3,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic              out_wr1,
    output logic              out_wr2,
`ifdef SCHED_STATS_EN
    output logic              out_wr3,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       conflict_cnt
`else
    output logic              out_wr3
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, ARB} state_t;

    state_t            state;
    logic              rden_q;
    logic [ADDR_W-1:0] wr_a   [3];
    logic [ADDR_W-1:0] rd_q   [3];
    logic [DATA_W-1:0] din    [3];
    logic [DATA_W-1:0] dout_q [3];
    logic [DATA_W-1:0] sel    [3];
    logic [1:0]        rr_q   [3];
    logic [2:0]        req    [3];
    logic [2:0]        gnt    [3];
    logic [2:0]        wr_q;
    logic [2:0]        ne, drop, adv, deny;

    assign wr_a[0] = in_wr_add1;
    assign wr_a[1] = in_wr_add2;
    assign wr_a[2] = in_wr_add3;
    assign din[0]  = in_data1;
    assign din[1]  = in_data2;
    assign din[2]  = in_data3;

    assign in_rd_add1 = rd_q[0];
    assign in_rd_add2 = rd_q[1];
    assign in_rd_add3 = rd_q[2];
    assign in_rden1   = rden_q;
    assign in_rden2   = rden_q;
    assign in_rden3   = rden_q;
    assign out_data1  = dout_q[0];
    assign out_data2  = dout_q[1];
    assign out_data3  = dout_q[2];
    assign out_wr1    = wr_q[0];
    assign out_wr2    = wr_q[1];
    assign out_wr3    = wr_q[2];

    // Search order rr, rr+1, rr+2 (mod 3); one-hot grant of the first requester.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] rr);
        logic [2:0] g;
        logic       found;
        logic [1:0] idx;
        g     = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(rr) + k) % 3);
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [1:0] nxt_rr(input logic [2:0] g, input logic [1:0] rr);
        logic [1:0] n;
        unique case (1'b1)
            g[0]:    n = 2'd1;
            g[1]:    n = 2'd2;
            g[2]:    n = 2'd0;
            default: n = rr;
        endcase
        return n;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ne[i]   = rd_q[i] != wr_a[i];
            drop[i] = ne[i] && (din[i][1:0] == 2'b00);
        end
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                req[j][i] = ne[i] && (din[i][1:0] == 2'(j + 1));
            end
            gnt[j] = pick(req[j], rr_q[j]);
            sel[j] = gnt[j][0] ? din[0] : (gnt[j][1] ? din[1] : din[2]);
        end
        for (int i = 0; i < 3; i++) begin
            adv[i]  = drop[i] | gnt[0][i] | gnt[1][i] | gnt[2][i];
            deny[i] = ne[i] && !drop[i] && !adv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rden_q <= 1'b0;
            wr_q   <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                rd_q[i]   <= '0;
                dout_q[i] <= '0;
                rr_q[i]   <= 2'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    wr_q   <= 3'b000;
                    rden_q <= enable;
                    state  <= enable ? FETCH : IDLE;
                end
                FETCH: begin
                    wr_q   <= 3'b000;
                    rden_q <= enable;
                    state  <= enable ? ARB : IDLE;
                end
                ARB: begin
                    for (int j = 0; j < 3; j++) begin
                        wr_q[j] <= |gnt[j];
                        rr_q[j] <= nxt_rr(gnt[j], rr_q[j]);
                        if (|gnt[j]) dout_q[j] <= sel[j];
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (adv[i]) rd_q[i] <= rd_q[i] + ADDR_W'(1);
                    end
                    rden_q <= enable;
                    state  <= enable ? FETCH : IDLE;
                end
                default: begin
                    wr_q   <= 3'b000;
                    rden_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [1:0]  n_drop, n_deny;
    logic [16:0] drop_sum, deny_sum;

    always_comb begin
        n_drop = 2'd0;
        n_deny = 2'd0;
        for (int i = 0; i < 3; i++) begin
            n_drop = n_drop + 2'(drop[i]);
            n_deny = n_deny + 2'(deny[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
        deny_sum = {1'b0, conflict_cnt} + 17'(n_deny);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt     <= 16'h0000;
            conflict_cnt <= 16'h0000;
        end else if (state == ARB) begin
            drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            conflict_cnt <= deny_sum[16] ? 16'hFFFF : deny_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Directed bench for switch_rr_scheduler: single-round vector table plus
// collision, wrap-around, mid-round reset and enable-drop sequences.
module tb_switch_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [11:0] wr1, wr2, wr3;
    logic [31:0] d1, d2, d3;
    logic [11:0] rd1, rd2, rd3;
    logic        re1, re2, re3;
    logic [31:0] o1, o2, o3;
    logic        w1, w2, w3;
`ifdef SCHED_STATS_EN
    logic [15:0] drop_cnt, conflict_cnt;
`endif

    logic [31:0] mem [3][4096];
    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= mem[0][rd1];
        d2 <= mem[1][rd2];
        d3 <= mem[2][rd3];
    end

    switch_rr_scheduler #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_wr_add1(wr1), .in_wr_add2(wr2), .in_wr_add3(wr3),
        .in_data1(d1), .in_data2(d2), .in_data3(d3),
        .in_rd_add1(rd1), .in_rd_add2(rd2), .in_rd_add3(rd3),
        .in_rden1(re1), .in_rden2(re2), .in_rden3(re3),
        .out_data1(o1), .out_data2(o2), .out_data3(o3),
        .out_wr1(w1), .out_wr2(w2),
`ifdef SCHED_STATS_EN
        .out_wr3(w3), .drop_cnt(drop_cnt), .conflict_cnt(conflict_cnt)
`else
        .out_wr3(w3)
`endif
    );

    typedef struct {
        logic [31:0] d [3];
        logic [2:0]  ne;
        logic [2:0]  ewr;
        logic [31:0] ed [3];
        logic [11:0] erd [3];
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", {29'd0, w3, w2, w1}, 32'd0);
        chk("rst_rden", {29'd0, re3, re2, re1}, 32'd0);
        chk("rst_rd", {rd3[7:0], rd2[7:0], rd1[7:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, input logic [2:0] ne,
                                input logic [2:0] ewr, input logic [31:0] e1, e2, e3,
                                input logic [11:0] r1, r2, r3);
        vec_t v;
        v.d[0] = a;  v.d[1] = b;  v.d[2] = c;
        v.ne = ne;   v.ewr = ewr;
        v.ed[0] = e1; v.ed[1] = e2; v.ed[2] = e3;
        v.erd[0] = r1; v.erd[1] = r2; v.erd[2] = r3;
        return v;
    endfunction

    initial begin
        int ptr [3];
        int rr2;
        int g;
        int nreq;
        int deny;
        int bad;
        logic [31:0] ex;

        rst_n = 1'b0;
        enable = 1'b0;
        wr1 = '0; wr2 = '0; wr3 = '0;
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 4096; a++) mem[p][a] = 32'h0;

        vecs[0] = mk(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 3'b111, 3'b111,
                     32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 12'd1, 12'd1, 12'd1);
        vecs[1] = mk(32'hAAAA_0001, 32'hBBBB_0001, 32'hCCCC_0001, 3'b111, 3'b001,
                     32'hAAAA_0001, 32'h0, 32'h0, 12'd1, 12'd0, 12'd0);
        vecs[2] = mk(32'hDEAD_0003, 32'h0B0B_0003, 32'h0C0C_0003, 3'b110, 3'b100,
                     32'h0, 32'h0, 32'h0B0B_0003, 12'd0, 12'd1, 12'd0);
        vecs[3] = mk(32'hABCD_0000, 32'h1234_0001, 32'h5678_0002, 3'b001, 3'b000,
                     32'h0, 32'h0, 32'h0, 12'd1, 12'd0, 12'd0);
        vecs[4] = mk(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 3'b000, 3'b000,
                     32'h0, 32'h0, 32'h0, 12'd0, 12'd0, 12'd0);
        vecs[5] = mk(32'h5555_0002, 32'h6666_0002, 32'h7777_0001, 3'b111, 3'b011,
                     32'h7777_0001, 32'h5555_0002, 32'h0, 12'd1, 12'd0, 12'd1);
        vecs[6] = mk(32'h8888_0003, 32'h9999_0000, 32'hAAAA_0002, 3'b111, 3'b110,
                     32'h0, 32'hAAAA_0002, 32'h8888_0003, 12'd1, 12'd1, 12'd1);

        for (int v = 0; v < 7; v++) begin
            for (int p = 0; p < 3; p++) mem[p][0] = vecs[v].d[p];
            wr1 = {11'd0, vecs[v].ne[0]};
            wr2 = {11'd0, vecs[v].ne[1]};
            wr3 = {11'd0, vecs[v].ne[2]};
            do_reset();
            step();
            step();
            chk($sformatf("v%0d_early_wr", v), {29'd0, w3, w2, w1}, 32'd0);
            step();
            chk($sformatf("v%0d_wr", v), {29'd0, w3, w2, w1}, {29'd0, vecs[v].ewr});
            chk($sformatf("v%0d_d1", v), o1, vecs[v].ed[0]);
            chk($sformatf("v%0d_d2", v), o2, vecs[v].ed[1]);
            chk($sformatf("v%0d_d3", v), o3, vecs[v].ed[2]);
            chk($sformatf("v%0d_rd1", v), {20'd0, rd1}, {20'd0, vecs[v].erd[0]});
            chk($sformatf("v%0d_rd2", v), {20'd0, rd2}, {20'd0, vecs[v].erd[1]});
            chk($sformatf("v%0d_rd3", v), {20'd0, rd3}, {20'd0, vecs[v].erd[2]});
`ifdef SCHED_STATS_EN
            if (v == 3) chk("v3_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
        end

        // Three-way collision on output 2, 4 words per input.
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 4; k++)
                mem[p][k] = (32'(p + 1) << 24) | (32'(k) << 4) | 32'h2;
        wr1 = 12'd4; wr2 = 12'd4; wr3 = 12'd4;
        do_reset();
        step();
        ptr[0] = 0; ptr[1] = 0; ptr[2] = 0;
        rr2 = 0;
        deny = 0;
        bad = 0;
        for (int r = 0; r < 12; r++) begin
            step();
            if (w2 !== 1'b0) bad++;
            step();
            nreq = 0;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (ptr[(rr2 + k) % 3] < 4) begin
                    nreq++;
                    if (g < 0) g = (rr2 + k) % 3;
                end
            end
            deny += nreq - 1;
            ex = mem[g][ptr[g]];
            ptr[g]++;
            rr2 = (g + 1) % 3;
            chk($sformatf("col_r%0d", r), {w2, o2[30:0]}, {1'b1, ex[30:0]});
        end
        chk("col_no_back2back", bad, 0);
        chk("col_rd_all4", {rd3[7:0], rd2[7:0], rd1[7:0]}, {8'd4, 8'd4, 8'd4});
`ifdef SCHED_STATS_EN
        chk("col_conflict_cnt", {16'd0, conflict_cnt}, deny);
`endif
        step();
        step();
        chk("col_empty_no_wr", {29'd0, w3, w2, w1}, 32'd0);

        // Reset asserted during ARB aborts the round.
        mem[0][0] = 32'h4242_0001;
        wr1 = 12'd1; wr2 = 12'd0; wr3 = 12'd0;
        do_reset();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_wr", {29'd0, w3, w2, w1}, 32'd0);
        chk("midrst_rd1", {20'd0, rd1}, 32'd0);
        step();
        chk("midrst_wr_after", {29'd0, w3, w2, w1}, 32'd0);

        // Wrap-around: drop words up to 0xFFE, then a dest-01 word at 0xFFF.
        for (int a = 0; a < 4095; a++) mem[0][a] = 32'h0000_0000;
        mem[0][4095] = 32'h1234_5671;
        wr1 = 12'hFFF; wr2 = 12'd0; wr3 = 12'd0;
        do_reset();
        step();
        bad = 0;
        for (int r = 0; r < 4095; r++) begin
            step();
            step();
            if ({w3, w2, w1} !== 3'b000) bad++;
        end
        chk("wrap_no_wr_on_drops", bad, 0);
        chk("wrap_rd1_fff", {20'd0, rd1}, 32'h0000_0FFF);
`ifdef SCHED_STATS_EN
        chk("wrap_drop_cnt", {16'd0, drop_cnt}, 32'd4095);
`endif
        wr1 = 12'h000;
        step();
        step();
        chk("wrap_wr", {29'd0, w3, w2, w1}, 32'd1);
        chk("wrap_d1", o1, 32'h1234_5671);
        chk("wrap_rd1_0", {20'd0, rd1}, 32'd0);
        step();
        step();
        chk("wrap_empty_wr", {29'd0, w3, w2, w1}, 32'd0);
        chk("wrap_empty_rd1", {20'd0, rd1}, 32'd0);

        // Enable drops during ARB; rr for output 1 must survive idle.
        mem[0][0] = 32'h1111_0001;
        mem[0][1] = 32'h1112_0001;
        mem[1][0] = 32'h2221_0001;
        wr1 = 12'd2; wr2 = 12'd1; wr3 = 12'd0;
        do_reset();
        step();
        step();
        enable = 1'b0;
        step();
        chk("endrop_wr", {29'd0, w3, w2, w1}, 32'd1);
        chk("endrop_d1", o1, 32'h1111_0001);
        chk("endrop_rden", {29'd0, re3, re2, re1}, 32'd0);
        step();
        chk("idle_wr", {29'd0, w3, w2, w1}, 32'd0);
        chk("idle_rden", {29'd0, re3, re2, re1}, 32'd0);
        step();
        chk("idle_rd", {rd3[7:0], rd2[7:0], rd1[7:0]}, {8'd0, 8'd0, 8'd1});
        enable = 1'b1;
        step();
        chk("resume_rden", {29'd0, re3, re2, re1}, 32'd7);
        step();
        step();
        chk("resume_wr", {29'd0, w3, w2, w1}, 32'd1);
        chk("resume_d1_rr", o1, 32'h2221_0001);
        chk("resume_rd", {rd3[7:0], rd2[7:0], rd1[7:0]}, {8'd0, 8'd1, 8'd1});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
